// File: rtl/sram_ctrl.sv
// sram_ctrl: single-access responder between the pixel_buffer client and a
// 256Kx16 asynchronous SRAM, with programmable read and write strobe widths.
// Optional feature macro: SRAM_RANGE_CHECK_EN. When defined, requests with
// address >= DEPTH are accepted, cost one busy clock, never reach the pins and
// set the sticky range_err flag. When undefined, range_err stays 0.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | ready, strobes high, bus not driven
// RD         | ce/oe/lanes low for RD_CYCLES clocks, capture on the last edge
// WR_SETUP   | ce low and data driven, we still high (address/data setup)
// WR_PULSE   | we and lanes low for WR_CYCLES clocks
// WR_HOLD    | we high again, data still driven (data hold)
// REJECT     | out-of-range request swallowed in one clock (range check only)
module sram_ctrl #(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2,
  parameter int DEPTH     = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] address,
  input  logic [15:0] data_write,
  input  logic        read,
  input  logic        write,
  output logic        ready,
  output logic [15:0] data_read,
  output logic        rd_valid,
  output logic        range_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_data_o,
  output logic        sram_data_oe,
  input  logic [15:0] sram_data_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_REJECT   = 3'd5;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef SRAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          rej_is_rd;
  logic          reject;

  // With the check disabled RANGE_EN folds this to 0 and REJECT is unreachable.
  assign reject = RANGE_EN && (32'(address) >= DEPTH_W);

  // Sequencer: accept, count down the strobe widths, capture read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rej_is_rd   <= 1'b0;
      sram_addr   <= '0;
      sram_data_o <= '0;
      data_read   <= '0;
      rd_valid    <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read || write) begin
            sram_addr <= address;
            rej_is_rd <= ~write;
            if (write) sram_data_o <= data_write;
            if (reject) begin
              state     <= S_REJECT;
              range_err <= 1'b1;
            end else if (write) begin
              state <= S_WR_SETUP;
            end else begin
              state <= S_RD;
              cnt   <= CW'(RD_CYCLES);
            end
          end
        end
        S_RD: begin
          if (cnt == CW'(1)) begin
            data_read <= sram_data_i;
            rd_valid  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WR_SETUP: begin
          state <= S_WR_PULSE;
          cnt   <= CW'(WR_CYCLES);
        end
        S_WR_PULSE: begin
          if (cnt == CW'(1)) state <= S_WR_HOLD;
          else               cnt   <= cnt - CW'(1);
        end
        S_WR_HOLD: state <= S_IDLE;
        S_REJECT: begin
          state <= S_IDLE;
          if (rej_is_rd) begin
            data_read <= '0;
            rd_valid  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset releases the pins at once.
  always_comb begin
    ready        = 1'b0;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_lb_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_data_oe = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_ub_n = 1'b0;
      end
      S_WR_SETUP: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
      end
      S_WR_PULSE: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = 1'b0;
        sram_lb_n    = 1'b0;
        sram_ub_n    = 1'b0;
        sram_data_oe = 1'b1;
      end
      S_WR_HOLD: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and randomized checks of sram_ctrl against a simple
// word-store reference model, with a behavioural SRAM attached to the pins.
module tb_sram_ctrl;

  localparam int RDC = 2;
  localparam int WRC = 2;
`ifdef SRAM_RANGE_CHECK_EN
  localparam int DEP = 38400;
`else
  localparam int DEP = 262144;
`endif

  logic        clk;
  logic        reset;
  logic [17:0] address;
  logic [15:0] data_write;
  logic        read;
  logic        write;
  logic        ready;
  logic [15:0] data_read;
  logic        rd_valid;
  logic        range_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_data_o;
  logic        sram_data_oe;
  logic [15:0] sram_data_i;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_ctrl #(.RD_CYCLES(RDC), .WR_CYCLES(WRC), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .address(address), .data_write(data_write),
    .read(read), .write(write), .ready(ready), .data_read(data_read),
    .rd_valid(rd_valid), .range_err(range_err), .sram_addr(sram_addr),
    .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background content of never-written words.
  function automatic logic [15:0] bg(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural asynchronous SRAM on the pins.
  logic [15:0] sram_mem [0:262143];
  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] <= bg(18'(i));
    sram_mem[18'h00050] <= 16'hA5C3;
  end
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_data_oe) sram_mem[sram_addr] <= sram_data_o;

  // Reference model: what a read of each word must return.
  logic [15:0] ref_mem [logic [17:0]];
  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
  endfunction

  // One access issued in the current (ready) cycle; inj>0 pulses read at T+inj.
  task automatic do_access(input bit rd, input bit wr, input logic [17:0] a,
                           input logic [15:0] d, input int inj);
    int busy, oe_c, we_c, doe_c, first_we, first_doe, rv_c;
    bit rd_eff;
    rd_eff = rd && !wr;
    chk("ready_at_accept", 32'(ready), 32'd1);
    address = a; data_write = d; read = rd; write = wr;
    tick();
    read = 1'b0; write = 1'b0;
    busy = 0; oe_c = 0; we_c = 0; doe_c = 0; rv_c = 0;
    first_we = -1; first_doe = -1;
    while (ready !== 1'b1 && busy < 20) begin
      busy++;
      read = (busy == inj);
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) begin we_c++; if (first_we < 0) first_we = busy; end
      if (sram_data_oe) begin doe_c++; if (first_doe < 0) first_doe = busy; end
      if (rd_valid) rv_c++;
      tick();
    end
    read = 1'b0;
    chk("busy_cycles", 32'(busy), wr ? 32'(WRC + 2) : 32'(RDC));
    chk("oe_low_cycles", 32'(oe_c), wr ? 32'd0 : 32'(RDC));
    chk("we_low_cycles", 32'(we_c), wr ? 32'(WRC) : 32'd0);
    chk("rd_valid_while_busy", 32'(rv_c), 32'd0);
    chk("sram_addr", 32'(sram_addr), 32'(a));
    if (wr) begin
      chk("we_start", 32'(first_we), 32'd2);
      chk("data_oe_start", 32'(first_doe), 32'd1);
      chk("data_oe_cycles", 32'(doe_c), 32'(WRC + 2));
      ref_mem[a] = d;
    end
    chk("rd_valid", 32'(rd_valid), 32'(rd_eff));
    if (rd_eff) chk("data_read", 32'(data_read), 32'(ref_rd(a)));
    chk("strobes_idle", strobes(), 32'h1F);
    chk("data_oe_idle", 32'(sram_data_oe), 32'd0);
  endtask

  // No request: controller must stay idle with the pins quiet.
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_strobes", strobes(), 32'h1F);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [17:0] ra;
    logic [15:0] rdat;
    int kind;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_write = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_strobes", strobes(), 32'h1F);
    chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_data_o", 32'(sram_data_o), 32'd0);
    chk("rst_data_read", 32'(data_read), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    ref_mem[18'h00050] = 16'hA5C3;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();

    // Directed read, then directed write, then write-wins.
    do_access(1'b1, 1'b0, 18'h00050, 16'h0000, 0);
    chk("first_read_value", 32'(data_read), 32'h0000A5C3);
    do_access(1'b0, 1'b1, 18'h12C00, 16'hFFFF, 0);
    chk("data_o_held", 32'(sram_data_o), 32'h0000FFFF);
    do_access(1'b1, 1'b1, 18'h00005, 16'h3C3C, 0);
    idle_check(2);
    do_access(1'b1, 1'b0, 18'h00005, 16'h0000, 0);
    do_access(1'b1, 1'b0, 18'h12C00, 16'h0000, 0);

    // Read pulsed at T+2 of a write is dropped.
    do_access(1'b0, 1'b1, 18'h00033, 16'h8001, 2);
    idle_check(3);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      ra   = 18'($urandom_range(0, 31));
      rdat = 16'($urandom);
      do_access(kind != 1, kind != 0, ra, rdat, 0);
    end

    // Reset in WR_PULSE releases the pins without a clock edge.
    do_access(1'b1, 1'b0, 18'h00050, 16'h0000, 0);
    address = 18'h3FFFF; data_write = 16'h1234; write = 1'b1;
    tick();
    write = 1'b0;
    tick();
    chk("we_low_before_reset", 32'(sram_we_n), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_we", 32'(sram_we_n), 32'd1);
    chk("rst_mid_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_mid_strobes", strobes(), 32'h1F);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_data_read", 32'(data_read), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_reset_ready", 32'(ready), 32'd1);
    do_access(1'b1, 1'b0, 18'h00050, 16'h0000, 0);

`ifdef SRAM_RANGE_CHECK_EN
    address = 18'd38401; data_write = 16'hBEEF; write = 1'b1;
    tick();
    write = 1'b0;
    chk("oor_busy", 32'(ready), 32'd0);
    chk("oor_strobes", strobes(), 32'h1F);
    chk("oor_data_oe", 32'(sram_data_oe), 32'd0);
    tick();
    chk("oor_ready", 32'(ready), 32'd1);
    chk("oor_range_err", 32'(range_err), 32'd1);
    chk("oor_wr_no_valid", 32'(rd_valid), 32'd0);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("oor_rd_strobes", strobes(), 32'h1F);
    tick();
    chk("oor_rd_valid", 32'(rd_valid), 32'd1);
    chk("oor_rd_data", 32'(data_read), 32'd0);
    do_access(1'b1, 1'b0, 18'h00050, 16'h0000, 0);
    chk("range_err_sticky", 32'(range_err), 32'd1);
`else
    chk("range_err_off", 32'(range_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
